// File: rtl/gcd_pkg.sv
// Shared definitions for the subtractive GCD engine: state encoding and
// the comparator flag bundle passed from datapath to controller.
package gcd_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] IDLE = 2'd0;
    localparam logic [STATE_W-1:0] CALC = 2'd1;
    localparam logic [STATE_W-1:0] DONE = 2'd2;

    typedef struct packed {
        logic x_zero;
        logic y_zero;
        logic eq;
        logic gt;
    } gcd_flags_t;

endpackage

// File: rtl/gcd_param_if.sv
// Request/result bundle of the GCD engine; the requester drives operands,
// the engine returns the result, status and step count.
interface gcd_param_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
);
    logic             go_i;
    logic [WIDTH-1:0] x_i;
    logic [WIDTH-1:0] y_i;
    logic [WIDTH-1:0] d_o;
    logic             done;
    logic             busy_o;
    logic             err_o;
    logic [CNT_W-1:0] iter_o;

    modport master (
        output go_i, x_i, y_i,
        input  d_o, done, busy_o, err_o, iter_o
    );

    modport slave (
        input  go_i, x_i, y_i,
        output d_o, done, busy_o, err_o, iter_o
    );
endinterface

// File: rtl/gcd_param_dp.sv
// GCD datapath: X/Y operand registers, comparators and the single shared
// subtractor that replaces the larger operand by the difference.
module gcd_param_dp
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic [WIDTH-1:0] x_q,
    output logic [WIDTH-1:0] y_q,
    output gcd_flags_t       flags_c
);

    always_comb begin
        flags_c        = '0;
        flags_c.x_zero = (x_q == '0);
        flags_c.y_zero = (y_q == '0);
        flags_c.eq     = (x_q == y_q);
        flags_c.gt     = (x_q > y_q);
    end

    // The compare guarantees the minuend is the larger value, so no borrow is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else if (load) begin
            x_q <= x_in;
            y_q <= y_in;
        end else if (step) begin
            if (flags_c.gt) begin
                x_q <= x_q - y_q;
            end else begin
                y_q <= y_q - x_q;
            end
        end
    end

endmodule

// File: rtl/gcd_param.sv
// Subtractive GCD engine: controller FSM plus result/status registers,
// driving the operand datapath in gcd_param_dp.
module gcd_param
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    gcd_param_if.slave  bus
);

    localparam logic [CNT_W-1:0] ITER_MAX = {CNT_W{1'b1}};

    logic [STATE_W-1:0] state_q, state_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [CNT_W-1:0]   iter_q, iter_d;
    logic               err_q, err_d;
    logic               done_q, busy_q;
    logic               load_c, step_c;
    logic [WIDTH-1:0]   x_q, y_q;
    gcd_flags_t         flags_c;

    gcd_param_dp #(.WIDTH(WIDTH)) u_dp (
        .clk     (clk),
        .reset   (reset),
        .load    (load_c),
        .step    (step_c),
        .x_in    (bus.x_i),
        .y_in    (bus.y_i),
        .x_q     (x_q),
        .y_q     (y_q),
        .flags_c (flags_c)
    );

    // Next state and next result values; one decision per CALC cycle.
    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        err_d   = err_q;
        iter_d  = iter_q;
        load_c  = 1'b0;
        step_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.go_i) begin
                    load_c  = 1'b1;
                    iter_d  = '0;
                    err_d   = 1'b0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (flags_c.x_zero && flags_c.y_zero) begin
                    d_d     = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (flags_c.x_zero) begin
                    d_d     = y_q;
                    state_d = DONE;
                end else if (flags_c.y_zero || flags_c.eq) begin
                    d_d     = x_q;
                    state_d = DONE;
                end else begin
                    step_c = 1'b1;
                    if (iter_q != ITER_MAX) begin
                        iter_d = iter_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (!bus.go_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            d_q     <= '0;
            err_q   <= 1'b0;
            iter_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            err_q   <= err_d;
            iter_q  <= iter_d;
            done_q  <= (state_d == DONE);
            busy_q  <= (state_d == CALC);
        end
    end

    assign bus.d_o    = d_q;
    assign bus.err_o  = err_q;
    assign bus.iter_o = iter_q;
    assign bus.done   = done_q;
    assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_gcd_param.sv
// Bench for gcd_param: table of operand pairs with known results, a few
// model-checked random pairs, and hand-written reset / hold sequences.
module tb_gcd_param;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0;
    logic [7:0] x = '0;
    logic [7:0] y = '0;

    always #5 clk = ~clk;

    gcd_param_if #(.WIDTH(8), .CNT_W(8)) bus ();
    gcd_param_if #(.WIDTH(8), .CNT_W(4)) bus4 ();

    assign bus.go_i  = go;
    assign bus.x_i   = x;
    assign bus.y_i   = y;
    assign bus4.go_i = go;
    assign bus4.x_i  = x;
    assign bus4.y_i  = y;

    gcd_param #(.WIDTH(8), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    gcd_param #(.WIDTH(8), .CNT_W(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    typedef struct {
        int x;
        int y;
        int d;
        int err;
        int iter;
    } vec_t;

    typedef struct {
        int d;
        int err;
        int iter;
        int lat;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic void model(input int vx, input int vy,
                                  output int d, output int err, output int it);
        int a = vx;
        int b = vy;
        it  = 0;
        err = 0;
        d   = 0;
        while (1) begin
            if (a == 0 && b == 0) begin
                d = 0; err = 1; break;
            end else if (a == 0) begin
                d = b; break;
            end else if (b == 0 || a == b) begin
                d = a; break;
            end else if (a > b) begin
                a = a - b;
            end else begin
                b = b - a;
            end
            it++;
        end
    endfunction

    // One transaction: go held until done, optional extra hold cycles, then release.
    task automatic run_vec(input int vx, input int vy, input int d, input int err,
                           input int it, input int hold);
        exp_t e;
        int   lat;
        bit   seen;
        int   it4;
        @(negedge clk);
        go = 1'b1;
        x  = 8'(vx);
        y  = 8'(vy);
        e.d = d; e.err = err; e.iter = it; e.lat = it + 2;
        sb.push_back(e);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 400) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            seen = bus.done;
            if (lat == 1 && !seen) begin
                check("busy_after_go", int'(bus.busy_o), 1);
                x = 8'($urandom);
                y = 8'($urandom);
            end
        end
        e = sb.pop_front();
        if (!seen) begin
            check("done_timeout", 0, 1);
        end else begin
            it4 = (e.iter > 15) ? 15 : e.iter;
            check("d_o", int'(bus.d_o), e.d);
            check("err_o", int'(bus.err_o), e.err);
            check("iter_o", int'(bus.iter_o), e.iter);
            check("latency", lat, e.lat);
            check("busy_in_done", int'(bus.busy_o), 0);
            check("done_cnt4", int'(bus4.done), 1);
            check("iter_o_cnt4", int'(bus4.iter_o), it4);
            check("d_o_cnt4", int'(bus4.d_o), e.d);
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_done", int'(bus.done), 1);
            check("hold_busy", int'(bus.busy_o), 0);
            check("hold_d_o", int'(bus.d_o), e.d);
            check("hold_iter", int'(bus.iter_o), e.iter);
        end
        go = 1'b0;
        @(negedge clk);
        check("idle_done", int'(bus.done), 0);
        check("idle_busy", int'(bus.busy_o), 0);
        check("idle_keep_d", int'(bus.d_o), e.d);
        check("idle_keep_iter", int'(bus.iter_o), e.iter);
    endtask

    initial begin
        int rd, rerr, rit, rx, ry;

        vecs[0] = '{x: 12,  y: 8,   d: 4,  err: 0, iter: 2};
        vecs[1] = '{x: 15,  y: 15,  d: 15, err: 0, iter: 0};
        vecs[2] = '{x: 0,   y: 9,   d: 9,  err: 0, iter: 0};
        vecs[3] = '{x: 0,   y: 0,   d: 0,  err: 1, iter: 0};
        vecs[4] = '{x: 255, y: 1,   d: 1,  err: 0, iter: 254};
        vecs[5] = '{x: 9,   y: 0,   d: 9,  err: 0, iter: 0};
        vecs[6] = '{x: 8,   y: 12,  d: 4,  err: 0, iter: 2};
        vecs[7] = '{x: 7,   y: 3,   d: 1,  err: 0, iter: 4};
        vecs[8] = '{x: 1,   y: 200, d: 1,  err: 0, iter: 199};

        reset = 1'b1;
        go    = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_done", int'(bus.done), 0);
        check("rst_busy", int'(bus.busy_o), 0);
        check("rst_d_o", int'(bus.d_o), 0);
        check("rst_err", int'(bus.err_o), 0);
        check("rst_iter", int'(bus.iter_o), 0);
        go    = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_idle", int'(bus.busy_o), 0);

        foreach (vecs[i]) begin
            run_vec(vecs[i].x, vecs[i].y, vecs[i].d, vecs[i].err, vecs[i].iter,
                    (i == 0) ? 3 : 0);
        end

        for (int n = 0; n < 4; n++) begin
            rx = int'($urandom_range(1, 60));
            ry = int'($urandom_range(1, 60));
            model(rx, ry, rd, rerr, rit);
            run_vec(rx, ry, rd, rerr, rit, 1);
        end

        // Reset three cycles into a long computation, with go still asserted.
        @(negedge clk);
        go = 1'b1;
        x  = 8'd255;
        y  = 8'd1;
        repeat (3) @(negedge clk);
        check("mid_calc_busy", int'(bus.busy_o), 1);
        check("mid_calc_iter", int'(bus.iter_o), 2);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", int'(bus.busy_o), 0);
        check("mid_rst_done", int'(bus.done), 0);
        check("mid_rst_d_o", int'(bus.d_o), 0);
        check("mid_rst_err", int'(bus.err_o), 0);
        check("mid_rst_iter", int'(bus.iter_o), 0);
        check("mid_rst_iter4", int'(bus4.iter_o), 0);
        reset = 1'b0;
        go    = 1'b0;
        @(negedge clk);
        check("mid_rst_stays_idle", int'(bus.busy_o), 0);
        run_vec(12, 8, 4, 0, 2, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
